// File: rtl/trig_master_pkg.sv
// Shared definitions for the trigger master: FSM encoding and frame layout.
package trig_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  localparam logic START_BIT = 1'b1;

  // Frame = start bit + token bits + even-parity bit.
  function automatic int frame_len(input int tbits);
    return tbits + 2;
  endfunction

endpackage

// File: rtl/trig_serializer.sv
// Load/shift register emitting one trigger frame on mtrig_o, MSB first.
module trig_serializer
  import trig_master_pkg::*;
#(
  parameter int TBITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [TBITS-1:0] tok_i,
  output logic             mtrig_o,
  output logic             last_o
);

  localparam int FLEN = frame_len(TBITS);
  localparam int CW   = $clog2(FLEN);

  logic [FLEN-1:0] sr_q, sr_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic            act_q, act_d;

  always_comb begin
    sr_d   = sr_q;
    bcnt_d = bcnt_q;
    act_d  = act_q;
    if (load_i) begin
      sr_d   = {START_BIT, tok_i, ^tok_i};
      bcnt_d = '0;
      act_d  = 1'b1;
    end else if (act_q) begin
      // Zeros shift in behind the frame, so the line idles low afterwards.
      sr_d = {sr_q[FLEN-2:0], 1'b0};
      if (bcnt_q == CW'(FLEN-1)) begin
        act_d  = 1'b0;
        bcnt_d = '0;
      end else begin
        bcnt_d = bcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '0;
      bcnt_q <= '0;
      act_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bcnt_q <= bcnt_d;
      act_q  <= act_d;
    end
  end

  assign mtrig_o = sr_q[FLEN-1];
  assign last_o  = act_q && (bcnt_q == CW'(FLEN-1));

endmodule

// File: rtl/trig_master.sv
// Trigger master: prescales requests, serializes a token frame, then holds off for a dead time.
module trig_master
  import trig_master_pkg::*;
#(
  parameter int TBITS  = 16,
  parameter int DTBITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigin,
  input  logic              enable,
  input  logic [15:0]       prescale,
  input  logic [DTBITS-1:0] deadtime,
  output logic              mtrig,
  output logic [TBITS-1:0]  token,
  output logic              tok_vld,
  output logic              busy,
  output logic [31:0]       cnt_acc,
  output logic [15:0]       cnt_lost
);

  state_e            state_q, state_d;
  logic [TBITS-1:0]  tokcnt_q, tokcnt_d, token_q, token_d;
  logic              tok_vld_q, tok_vld_d, busy_q;
  logic [31:0]       acc_q, acc_d;
  logic [15:0]       lost_q, lost_d, ps_q, ps_d;
  logic [DTBITS-1:0] dcnt_q, dcnt_d;
  logic              accept, ser_last;

  always_comb begin
    state_d   = state_q;
    tokcnt_d  = tokcnt_q;
    token_d   = token_q;
    tok_vld_d = 1'b0;
    acc_d     = acc_q;
    lost_d    = lost_q;
    ps_d      = ps_q;
    dcnt_d    = dcnt_q;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && trigin) begin
          if (ps_q == prescale) begin
            // Dead time is latched here so mid-frame changes hit the next trigger.
            accept    = 1'b1;
            ps_d      = '0;
            state_d   = ST_SEND;
            tok_vld_d = 1'b1;
            token_d   = tokcnt_q;
            tokcnt_d  = tokcnt_q + TBITS'(1);
            acc_d     = acc_q + 32'd1;
            dcnt_d    = deadtime;
          end else begin
            ps_d = ps_q + 16'd1;
          end
        end
      end
      ST_SEND: begin
        if (ser_last) state_d = (dcnt_q == '0) ? ST_IDLE : ST_DEAD;
      end
      ST_DEAD: begin
        if (dcnt_q <= DTBITS'(1)) begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q - DTBITS'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) ps_d = '0;
    if ((state_q != ST_IDLE) && trigin && (lost_q != 16'hFFFF)) lost_d = lost_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tokcnt_q  <= '0;
      token_q   <= '0;
      tok_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      acc_q     <= '0;
      lost_q    <= '0;
      ps_q      <= '0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      tokcnt_q  <= tokcnt_d;
      token_q   <= token_d;
      tok_vld_q <= tok_vld_d;
      busy_q    <= (state_d != ST_IDLE);
      acc_q     <= acc_d;
      lost_q    <= lost_d;
      ps_q      <= ps_d;
      dcnt_q    <= dcnt_d;
    end
  end

  trig_serializer #(.TBITS(TBITS)) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .tok_i   (tokcnt_q),
    .mtrig_o (mtrig),
    .last_o  (ser_last)
  );

  assign token    = token_q;
  assign tok_vld  = tok_vld_q;
  assign busy     = busy_q;
  assign cnt_acc  = acc_q;
  assign cnt_lost = lost_q;

endmodule

// File: tb/tb_trig_master.sv
// Directed bench for trig_master; a 4-bit-token instance covers token wraparound.
module tb_trig_master;

  logic        clk = 1'b0;
  logic        reset, trigin, enable;
  logic [15:0] prescale, deadtime;
  logic        mtrig, tok_vld, busy;
  logic [15:0] token, cnt_lost;
  logic [31:0] cnt_acc;

  logic        trigin_w;
  logic        mtrig_w, tok_vld_w, busy_w;
  logic [3:0]  token_w;
  logic [15:0] cnt_lost_w;
  logic [31:0] cnt_acc_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trig_master #(.TBITS(16), .DTBITS(16)) dut (
    .clk(clk), .reset(reset), .trigin(trigin), .enable(enable),
    .prescale(prescale), .deadtime(deadtime),
    .mtrig(mtrig), .token(token), .tok_vld(tok_vld), .busy(busy),
    .cnt_acc(cnt_acc), .cnt_lost(cnt_lost)
  );

  trig_master #(.TBITS(4), .DTBITS(16)) dut_w (
    .clk(clk), .reset(reset), .trigin(trigin_w), .enable(1'b1),
    .prescale(16'd0), .deadtime(16'd0),
    .mtrig(mtrig_w), .token(token_w), .tok_vld(tok_vld_w), .busy(busy_w),
    .cnt_acc(cnt_acc_w), .cnt_lost(cnt_lost_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse();
    trigin = 1'b1;
    step();
    trigin = 1'b0;
  endtask

  // Called in the tok_vld cycle; walks all 18 frame bits.
  task automatic check_frame(input string tag, input logic [15:0] exp_tok, input logic [17:0] frame);
    chk({tag, "_vld"}, {31'd0, tok_vld}, 32'd1);
    chk({tag, "_tok"}, {16'd0, token}, {16'd0, exp_tok});
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), {31'd0, mtrig}, {31'd0, frame[17-i]});
      chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
      step();
    end
    chk({tag, "_tail"}, {31'd0, mtrig}, 32'd0);
  endtask

  initial begin
    logic [5:0] fw;
    reset = 1'b1; trigin = 1'b1; trigin_w = 1'b1;
    enable = 1'b1; prescale = 16'd0; deadtime = 16'd0;
    step(); step();
    reset = 1'b0; trigin = 1'b0; trigin_w = 1'b0;
    chk("rst_mtrig", {31'd0, mtrig}, 32'd0);
    chk("rst_vld",   {31'd0, tok_vld}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_token", {16'd0, token}, 32'd0);
    chk("rst_acc",   cnt_acc, 32'd0);
    chk("rst_lost",  {16'd0, cnt_lost}, 32'd0);

    // 4-bit token wrap: 15 frames, then token F (frame 1_1111_0), then 0.
    for (int n = 0; n < 15; n++) begin
      trigin_w = 1'b1; step(); trigin_w = 1'b0;
      repeat (6) step();
    end
    trigin_w = 1'b1; step(); trigin_w = 1'b0;
    chk("wrap_vld", {31'd0, tok_vld_w}, 32'd1);
    chk("wrap_tokF", {28'd0, token_w}, 32'hF);
    fw = 6'b111110;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wrap_bit%0d", i), {31'd0, mtrig_w}, {31'd0, fw[5-i]});
      step();
    end
    chk("wrap_acc", cnt_acc_w, 32'd16);
    trigin_w = 1'b1; step(); trigin_w = 1'b0;
    chk("wrap_tok0", {28'd0, token_w}, 32'd0);
    repeat (6) step();

    // Basic frames, prescale 0, no dead time.
    pulse();
    check_frame("f0", 16'h0000, 18'b1_0000000000000000_0);
    chk("f0_idle", {31'd0, busy}, 32'd0);
    chk("f0_acc", cnt_acc, 32'd1);
    pulse();
    check_frame("f1", 16'h0001, 18'b1_0000000000000001_1);
    chk("f1_acc", cnt_acc, 32'd2);

    // Prescale 3: only the 4th and 8th requests go out.
    prescale = 16'd3;
    for (int i = 0; i < 8; i++) begin
      pulse();
      chk($sformatf("ps_vld%0d", i), {31'd0, tok_vld}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
      repeat (20) step();
    end
    chk("ps_acc", cnt_acc, 32'd4);
    prescale = 16'd0;

    // Dead time 10: offsets counted from the tok_vld cycle; busy spans +0..+27.
    deadtime = 16'd10;
    pulse();
    chk("dt_tok", {16'd0, token}, 32'd4);
    for (int k = 0; k < 28; k++) begin
      chk($sformatf("dt_busy%0d", k), {31'd0, busy}, 32'd1);
      if (k == 20) chk("dt_mtrig_dead", {31'd0, mtrig}, 32'd0);
      trigin = (k == 5 || k == 27);
      step();
      trigin = 1'b0;
    end
    chk("dt_idle28", {31'd0, busy}, 32'd0);
    chk("dt_lost", {16'd0, cnt_lost}, 32'd2);
    pulse();
    chk("dt_acc28_vld", {31'd0, tok_vld}, 32'd1);
    chk("dt_acc28_tok", {16'd0, token}, 32'd5);
    repeat (28) step();
    chk("dt_end_idle", {31'd0, busy}, 32'd0);
    chk("dt_acc", cnt_acc, 32'd6);

    // Disabled request is ignored entirely.
    enable = 1'b0;
    pulse();
    chk("dis_vld", {31'd0, tok_vld}, 32'd0);
    chk("dis_busy", {31'd0, busy}, 32'd0);
    chk("dis_acc", cnt_acc, 32'd6);
    chk("dis_lost", {16'd0, cnt_lost}, 32'd2);
    enable = 1'b1;

    // Long dead time; hold trigin high to saturate the lost counter.
    deadtime = 16'hFFFF;
    trigin = 1'b1;
    step();
    chk("sat_vld", {31'd0, tok_vld}, 32'd1);
    repeat (65540) step();
    trigin = 1'b0;
    chk("sat_lost", {16'd0, cnt_lost}, 32'hFFFF);
    chk("sat_busy", {31'd0, busy}, 32'd1);
    chk("sat_acc", cnt_acc, 32'd7);

    // Reset mid-frame at bit 5, then a clean frame.
    reset = 1'b1; step(); reset = 1'b0;
    deadtime = 16'd0;
    pulse();
    chk("mr_tok", {16'd0, token}, 32'd0);
    repeat (5) step();
    chk("mr_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_mtrig", {31'd0, mtrig}, 32'd0);
    chk("mr_token", {16'd0, token}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_acc", cnt_acc, 32'd0);
    step();
    pulse();
    check_frame("mr_f", 16'h0000, 18'b1_0000000000000000_0);
    chk("mr_acc1", cnt_acc, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
